// File: rtl/waveform_frame_ctrl.sv
// waveform_frame_ctrl
// Frame sequencer between the sample-to-pixel plotter and the pixel framebuffer.
// Each frame does four things in order:
//   - clear the back buffer;
//   - let the plotter draw one screen width of columns;
//   - wait for a VGA vsync falling edge;
//   - swap the buffers.
// The controller owns the framebuffer write port and picks the clear engine or
// the plotter as its source each cycle.
// Optional feature macro: WAVEFORM_DOUBLE_BUFFER_EN. When it is defined,
// fb_back_sel toggles on every swap. When it is undefined, fb_back_sel is held
// at 0, giving a single buffer.

module waveform_frame_ctrl #(
  parameter int SCREEN_WIDTH  = 640,
  parameter int SCREEN_HEIGHT = 480,
  parameter int ADDR_WIDTH    = $clog2(SCREEN_WIDTH * SCREEN_HEIGHT)
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  run,
  input  logic                  vga_vsync,
  input  logic [ADDR_WIDTH-1:0] plot_addr,
  input  logic                  plot_data,
  input  logic                  plot_wr_en,
  input  logic                  plot_col_done,
  output logic                  plot_resetn,
  output logic                  plot_enable,
  output logic [ADDR_WIDTH-1:0] fb_addr,
  output logic                  fb_data,
  output logic                  fb_wr_en,
  output logic                  fb_back_sel,
  output logic                  frame_done,
  output logic                  overrun_err
);

  localparam int PIXELS    = SCREEN_WIDTH * SCREEN_HEIGHT;
  localparam int COL_WIDTH = $clog2(SCREEN_WIDTH + 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(PIXELS - 1);
  localparam logic [COL_WIDTH-1:0]  LAST_COL  = COL_WIDTH'(SCREEN_WIDTH - 1);

  typedef enum logic [2:0] {
    HOLD,
    CLEAR,
    PLOT,
    WAIT_VSYNC,
    SWAP
  } state_t;

  state_t state;
  state_t state_next;

  logic [ADDR_WIDTH-1:0] clear_addr;
  logic [ADDR_WIDTH-1:0] clear_addr_next;
  logic [COL_WIDTH-1:0]  col_count;
  logic [COL_WIDTH-1:0]  col_count_next;
  logic                  vsync_q;
  logic                  vsync_fall;

  logic [ADDR_WIDTH-1:0] fb_addr_next;
  logic                  fb_data_next;
  logic                  fb_wr_en_next;
  logic                  plot_enable_next;
  logic                  plot_resetn_next;
  logic                  back_sel_next;
  logic                  frame_done_next;
  logic                  overrun_next;

  // A falling edge is a high registered copy together with a low live level.
  assign vsync_fall = vsync_q & ~vga_vsync;

  // State register; reset abandons any frame and restarts with a full clear.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= CLEAR;
    end else begin
      state <= state_next;
    end
  end

  // Counters, the vsync history and all registered outputs.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      clear_addr  <= '0;
      col_count   <= '0;
      vsync_q     <= 1'b1;
      fb_addr     <= '0;
      fb_data     <= 1'b0;
      fb_wr_en    <= 1'b0;
      plot_enable <= 1'b0;
      plot_resetn <= 1'b0;
      fb_back_sel <= 1'b0;
      frame_done  <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      clear_addr  <= clear_addr_next;
      col_count   <= col_count_next;
      vsync_q     <= vga_vsync;
      fb_addr     <= fb_addr_next;
      fb_data     <= fb_data_next;
      fb_wr_en    <= fb_wr_en_next;
      plot_enable <= plot_enable_next;
      plot_resetn <= plot_resetn_next;
      fb_back_sel <= back_sel_next;
      frame_done  <= frame_done_next;
      overrun_err <= overrun_next;
    end
  end

  // Next-state logic and write-port arbitration. Outputs are computed from the
  // next state so that the registered versions line up with the state itself.
  always_comb begin
    state_next       = state;
    clear_addr_next  = clear_addr;
    col_count_next   = col_count;
    fb_addr_next     = fb_addr;
    fb_data_next     = fb_data;
    fb_wr_en_next    = 1'b0;
    frame_done_next  = 1'b0;
    back_sel_next    = fb_back_sel;
    overrun_next     = overrun_err | (plot_wr_en & (state != PLOT));

    case (state)
      CLEAR: begin
        fb_wr_en_next = 1'b1;
        fb_addr_next  = clear_addr;
        fb_data_next  = 1'b0;
        if (clear_addr == LAST_ADDR) begin
          clear_addr_next = '0;
          state_next      = PLOT;
        end else begin
          clear_addr_next = clear_addr + ADDR_WIDTH'(1);
        end
      end
      PLOT: begin
        if (plot_wr_en) begin
          fb_wr_en_next = 1'b1;
          fb_addr_next  = plot_addr;
          fb_data_next  = plot_data;
        end
        if (plot_col_done) begin
          if (col_count == LAST_COL) begin
            col_count_next = '0;
            state_next     = WAIT_VSYNC;
          end else begin
            col_count_next = col_count + COL_WIDTH'(1);
          end
        end
      end
      WAIT_VSYNC: begin
        if (vsync_fall) begin
          state_next = SWAP;
        end
      end
      SWAP: begin
        frame_done_next = 1'b1;
`ifdef WAVEFORM_DOUBLE_BUFFER_EN
        back_sel_next = ~fb_back_sel;
`else
        back_sel_next = 1'b0;
`endif
        state_next = run ? CLEAR : HOLD;
      end
      HOLD: begin
        if (run) begin
          state_next = CLEAR;
        end
      end
      default: begin
        state_next = CLEAR;
      end
    endcase

    plot_enable_next = (state_next == PLOT);
    plot_resetn_next = (state_next == PLOT) || (state_next == WAIT_VSYNC) ||
                       (state_next == SWAP);
  end

endmodule

// File: tb/tb_waveform_frame_ctrl.sv
// Self-checking bench for waveform_frame_ctrl using a small 8x4 screen.
// Expected values come from the frame rules below:
//   - a clear writes every address in order;
//   - plotter writes appear one cycle later, but only while plotting;
//   - a swap follows the first vsync fall seen while waiting;
//   - overrun_err is sticky until reset.
// The expected fb_back_sel follows WAVEFORM_DOUBLE_BUFFER_EN.

module tb_waveform_frame_ctrl;

  localparam int W  = 8;
  localparam int H  = 4;
  localparam int N  = W * H;
  localparam int AW = $clog2(N);

  logic          clk;
  logic          resetn;
  logic          run;
  logic          vga_vsync;
  logic [AW-1:0] plot_addr;
  logic          plot_data;
  logic          plot_wr_en;
  logic          plot_col_done;
  logic          plot_resetn;
  logic          plot_enable;
  logic [AW-1:0] fb_addr;
  logic          fb_data;
  logic          fb_wr_en;
  logic          fb_back_sel;
  logic          frame_done;
  logic          overrun_err;

  int checks = 0;
  int errors = 0;
  logic exp_back_sel = 1'b0;
  logic exp_overrun  = 1'b0;

  waveform_frame_ctrl #(
    .SCREEN_WIDTH (W),
    .SCREEN_HEIGHT(H),
    .ADDR_WIDTH   (AW)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .run          (run),
    .vga_vsync    (vga_vsync),
    .plot_addr    (plot_addr),
    .plot_data    (plot_data),
    .plot_wr_en   (plot_wr_en),
    .plot_col_done(plot_col_done),
    .plot_resetn  (plot_resetn),
    .plot_enable  (plot_enable),
    .fb_addr      (fb_addr),
    .fb_data      (fb_data),
    .fb_wr_en     (fb_wr_en),
    .fb_back_sel  (fb_back_sel),
    .frame_done   (frame_done),
    .overrun_err  (overrun_err)
  );

  // Free-running clock with a 10-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock edge; outputs are then read 1 unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives all plotter inputs to their idle values.
  task automatic drive_idle();
    plot_wr_en    = 1'b0;
    plot_col_done = 1'b0;
    plot_addr     = '0;
    plot_data     = 1'b0;
  endtask

  // Flips the expected back-buffer index on a swap, if double buffering is on.
  task automatic model_swap();
`ifdef WAVEFORM_DOUBLE_BUFFER_EN
    exp_back_sel = ~exp_back_sel;
`endif
  endtask

  // Holds reset and checks every output against its reset value.
  task automatic test_reset();
    logic [AW+6:0] obs;
    resetn    = 1'b0;
    run       = 1'b1;
    vga_vsync = 1'b1;
    drive_idle();
    step();
    step();
    exp_back_sel = 1'b0;
    exp_overrun  = 1'b0;
    obs = {fb_addr, fb_data, fb_wr_en, plot_enable, plot_resetn, fb_back_sel,
           frame_done, overrun_err};
    checks++;
    if (obs !== '0) begin
      errors++;
      $display("[TB] FAIL reset_values got %b want all zero", obs);
    end
  endtask

  // A full clear must write addresses 0..N-1 with data 0 on consecutive edges.
  // Stray column pulses are sent during the clear and must be ignored. If
  // inject_at is not -1, one plotter write is sent at that index; it must be
  // dropped and must set overrun_err.
  task automatic test_clear(input int inject_at);
    logic [4:0] exp_ctrl;
    for (int i = 0; i < N; i++) begin
      plot_col_done = ($urandom_range(0, 2) == 0);
      plot_wr_en    = (i == inject_at);
      plot_addr     = AW'($urandom_range(0, N - 1));
      plot_data     = 1'b1;
      if (i == inject_at) exp_overrun = 1'b1;
      step();
      checks++;
      if (fb_wr_en !== 1'b1 || fb_addr !== AW'(i) || fb_data !== 1'b0) begin
        errors++;
        $display("[TB] FAIL clear_write i=%0d got we=%b addr=%0d data=%b want we=1 addr=%0d data=0",
                 i, fb_wr_en, fb_addr, fb_data, i);
      end
      exp_ctrl = {(i == N - 1), (i == N - 1), 1'b0, exp_overrun, exp_back_sel};
      checks++;
      if ({plot_enable, plot_resetn, frame_done, overrun_err, fb_back_sel} !== exp_ctrl) begin
        errors++;
        $display("[TB] FAIL clear_ctrl i=%0d got en/rn/fd/ov/bs=%b want %b", i,
                 {plot_enable, plot_resetn, frame_done, overrun_err, fb_back_sel}, exp_ctrl);
      end
    end
    drive_idle();
  endtask

  // Plots `cols` columns of random length with random writes. Each write must
  // reach the framebuffer one edge later, and plot_enable must drop right after
  // the final column. The vsync falls and recovers at column 2, which must be
  // ignored while plotting. If edge_at_end is set, vsync also falls on the
  // final column pulse; that edge must be missed.
  task automatic test_plot(input int cols, input bit edge_at_end);
    int done_cols;
    int len;
    logic wr;
    logic dat;
    logic last;
    logic [AW-1:0] a;
    logic [5:0] exp_ctrl;
    done_cols = 0;
    while (done_cols < cols) begin
      len = $urandom_range(1, 4);
      for (int c = 0; c < len; c++) begin
        wr  = 1'($urandom_range(0, 1));
        dat = 1'($urandom_range(0, 1));
        a   = AW'($urandom_range(0, N - 1));
        if (done_cols == 0 && c == 0) begin
          wr  = 1'b1;
          dat = 1'b1;
          a   = AW'(5);
        end
        last = (c == len - 1);
        plot_wr_en    = wr;
        plot_data     = dat;
        plot_addr     = a;
        plot_col_done = last;
        vga_vsync     = !((done_cols == 2 && c == 0) ||
                          (edge_at_end && last && done_cols == W - 1));
        step();
        if (last) done_cols++;
        exp_ctrl = {wr, (done_cols < W), 1'b1, 1'b0, exp_overrun, exp_back_sel};
        checks++;
        if ({fb_wr_en, plot_enable, plot_resetn, frame_done, overrun_err, fb_back_sel} !== exp_ctrl) begin
          errors++;
          $display("[TB] FAIL plot_ctrl col=%0d got we/en/rn/fd/ov/bs=%b want %b", done_cols,
                   {fb_wr_en, plot_enable, plot_resetn, frame_done, overrun_err, fb_back_sel},
                   exp_ctrl);
        end
        if (wr) begin
          checks++;
          if (fb_addr !== a || fb_data !== dat) begin
            errors++;
            $display("[TB] FAIL plot_forward col=%0d got addr=%0d data=%b want addr=%0d data=%b",
                     done_cols, fb_addr, fb_data, a, dat);
          end
        end
      end
    end
    drive_idle();
  endtask

  // Waits for vsync and then checks the swap. If missed_edge is set, vsync
  // already fell on the final column pulse and must not trigger a swap.
  // run_val is the run level sampled during the swap.
  task automatic test_swap(input bit missed_edge, input bit run_val);
    int wait_len;
    if (missed_edge) begin
      for (int i = 0; i < 3; i++) begin
        step();
        checks++;
        if ({frame_done, plot_enable, plot_resetn, fb_wr_en, overrun_err} !== {4'b0010, exp_overrun}) begin
          errors++;
          $display("[TB] FAIL missed_edge_wait i=%0d got fd/en/rn/we/ov=%b want %b", i,
                   {frame_done, plot_enable, plot_resetn, fb_wr_en, overrun_err},
                   {4'b0010, exp_overrun});
        end
      end
    end
    vga_vsync = 1'b1;
    wait_len = $urandom_range(1, 4);
    for (int i = 0; i < wait_len; i++) begin
      step();
      checks++;
      if ({frame_done, plot_enable, plot_resetn, fb_wr_en, overrun_err} !== {4'b0010, exp_overrun}) begin
        errors++;
        $display("[TB] FAIL vsync_wait i=%0d got fd/en/rn/we/ov=%b want %b", i,
                 {frame_done, plot_enable, plot_resetn, fb_wr_en, overrun_err},
                 {4'b0010, exp_overrun});
      end
    end
    vga_vsync = 1'b0;
    run       = run_val;
    step();
    checks++;
    if (frame_done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL swap_early got frame_done=%b want 0", frame_done);
    end
    vga_vsync = 1'b1;
    step();
    model_swap();
    checks++;
    if ({frame_done, fb_back_sel, plot_enable, plot_resetn, fb_wr_en, overrun_err} !==
        {1'b1, exp_back_sel, 3'b000, exp_overrun}) begin
      errors++;
      $display("[TB] FAIL swap_pulse got fd/bs/en/rn/we/ov=%b want %b",
               {frame_done, fb_back_sel, plot_enable, plot_resetn, fb_wr_en, overrun_err},
               {1'b1, exp_back_sel, 3'b000, exp_overrun});
    end
  endtask

  // Idles with run low for 100 cycles and then raises run. The following clear
  // must start again at address 0.
  task automatic test_hold();
    for (int i = 0; i < 100; i++) begin
      plot_col_done = ($urandom_range(0, 3) == 0);
      step();
      checks++;
      if ({fb_wr_en, plot_resetn, plot_enable, frame_done, overrun_err} !== {4'b0000, exp_overrun}) begin
        errors++;
        $display("[TB] FAIL hold_idle i=%0d got we/rn/en/fd/ov=%b want %b", i,
                 {fb_wr_en, plot_resetn, plot_enable, frame_done, overrun_err},
                 {4'b0000, exp_overrun});
      end
    end
    plot_col_done = 1'b0;
    run = 1'b1;
    step();
    checks++;
    if ({fb_wr_en, plot_resetn, plot_enable} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL hold_exit got we/rn/en=%b want 000", {fb_wr_en, plot_resetn, plot_enable});
    end
    test_clear(-1);
  endtask

  // Asserts reset after three columns of a frame. Reset must abandon the frame,
  // clear overrun_err and fb_back_sel, and force a full clear from address 0.
  task automatic test_reset_mid_plot();
    logic [AW+6:0] obs;
    test_plot(3, 1'b0);
    resetn = 1'b0;
    step();
    exp_back_sel = 1'b0;
    exp_overrun  = 1'b0;
    obs = {fb_addr, fb_data, fb_wr_en, plot_enable, plot_resetn, fb_back_sel,
           frame_done, overrun_err};
    checks++;
    if (obs !== '0) begin
      errors++;
      $display("[TB] FAIL mid_plot_reset got %b want all zero", obs);
    end
    resetn = 1'b1;
    test_clear(-1);
  endtask

  // Runs the scenarios in sequence and prints the summary line.
  initial begin
    test_reset();
    resetn = 1'b1;

    test_clear(-1);
    test_plot(W, 1'b1);
    test_swap(1'b1, 1'b1);

    test_clear(10);
    test_plot(W, 1'b0);
    test_swap(1'b0, 1'b0);

    test_hold();
    test_plot(W, 1'b0);
    test_swap(1'b0, 1'b1);

    test_clear(-1);
    test_reset_mid_plot();
    test_plot(W, 1'b1);
    test_swap(1'b1, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/waveform_frame_ctrl.md
# waveform_frame_ctrl

Frame-level controller for the waveform plotting datapath. Sits between the sample-to-pixel plotter and the pixel framebuffer. Sequences each frame:
- clears the back buffer;
- enables the plotter for exactly one screen width of columns;
- waits for VGA vertical sync;
- swaps front and back buffers.

It owns the framebuffer write port and decides, cycle by cycle, whether the clear engine or the plotter drives it.

## Interface
Parameters:
- SCREEN_WIDTH, 640, columns per frame.
- SCREEN_HEIGHT, 480, rows per frame.
- ADDR_WIDTH, $clog2(SCREEN_WIDTH*SCREEN_HEIGHT), framebuffer address width.

Ports:
- clk  in  1  single system clock; all logic on rising edge.
- resetn  in  1  synchronous, active-low reset.
- run  in  1  level; permits a new frame to start.
- vga_vsync  in  1  VGA vertical sync level, active-low.
- plot_addr  in  ADDR_WIDTH  plotter pixel address.
- plot_data  in  1  plotter pixel value.
- plot_wr_en  in  1  plotter write strobe.
- plot_col_done  in  1  one-cycle pulse per completed column (line-draw complete).
- plot_resetn  out  1  active-low reset to the plotter; low holds its column counter at 0.
- plot_enable  out  1  high only in PLOT.
- fb_addr  out  ADDR_WIDTH  framebuffer write address.
- fb_data  out  1  framebuffer write data.
- fb_wr_en  out  1  framebuffer write strobe.
- fb_back_sel  out  1  buffer index being written; the display reads the other buffer.
- frame_done  out  1  one-cycle pulse on each swap.
- overrun_err  out  1  sticky; set on a plotter write outside PLOT.

## Operation
States: HOLD, CLEAR, PLOT, WAIT_VSYNC, SWAP.
- On reset: state CLEAR.
- Register reset values: clear_addr=0, col_count=0.
- Output reset values: fb_addr=0, fb_data=0, fb_wr_en=0, plot_enable=0, plot_resetn=0, fb_back_sel=0, frame_done=0, overrun_err=0.

CLEAR:
- Writes fb_data=0 to addresses 0 .. SCREEN_WIDTH*SCREEN_HEIGHT-1, one per cycle, ascending.
- plot_resetn=0 throughout.
- After the write to the last address, go to PLOT; clear_addr returns to 0.

PLOT:
- plot_resetn=1, plot_enable=1.
- Every plot_wr_en cycle is forwarded: fb_addr<=plot_addr, fb_data<=plot_data, fb_wr_en<=1.
- col_count increments on each plot_col_done.
- When the pulse brings col_count to SCREEN_WIDTH, go to WAIT_VSYNC; col_count resets to 0.
- A plot_wr_en in the same cycle as that final plot_col_done is still forwarded.

WAIT_VSYNC:
- plot_enable=0; plot_resetn stays 1.
- Waits for a vga_vsync falling edge, detected against a one-cycle registered copy of vga_vsync.

SWAP:
- Lasts one cycle.
- fb_back_sel toggles and frame_done pulses.
- Next state is CLEAR if run=1, otherwise HOLD.

HOLD:
- plot_resetn=0, plot_enable=0.
- Goes to CLEAR in the cycle after run is sampled high.

Boundary rules:
- A plot_wr_en in any state other than PLOT is dropped and sets overrun_err. Only reset clears it.
- A vsync edge outside WAIT_VSYNC is ignored. An edge in the same cycle as the PLOT→WAIT_VSYNC transition is also missed; the controller waits for the next edge.
- run is sampled only in SWAP and HOLD. A frame in progress always completes.
- Reset mid-frame abandons the frame. fb_back_sel returns to 0 and a full clear restarts at address 0.
- Extra plot_col_done pulses outside PLOT are ignored.

## Timing
- All outputs are registered.
- Plotter-to-framebuffer write latency is exactly 1 cycle.
- CLEAR lasts exactly SCREEN_WIDTH*SCREEN_HEIGHT cycles of fb_wr_en=1.
- The first clear write (address 0) is the first cycle after the state enters CLEAR.
- After reset deasserts, the first fb_wr_en appears 1 cycle later.
- The vsync edge sampled in WAIT_VSYNC produces SWAP on the next cycle; frame_done and the fb_back_sel toggle are visible the cycle after SWAP.
- plot_enable falls on the cycle after the final plot_col_done.

## Configuration
Macro: WAVEFORM_DOUBLE_BUFFER_EN.
- Defined: fb_back_sel toggles on every SWAP, as described above.
- Undefined:
  - fb_back_sel is tied to 0, giving a single buffer.
  - SWAP still pulses frame_done.
  - CLEAR still runs, so visible tearing during the clear is accepted.

## Test plan
- Release reset with run=1 and SCREEN_WIDTH=8, SCREEN_HEIGHT=4 → 32 consecutive fb_wr_en with fb_data=0 and addresses 0..31, then plot_enable=1.
- In PLOT, drive plot_wr_en with addr=5, data=1 → next cycle fb_addr=5, fb_data=1, fb_wr_en=1. After 8 plot_col_done pulses, plot_enable=0.
- In WAIT_VSYNC, drop vga_vsync from 1 to 0 → SWAP, then frame_done=1 and fb_back_sel 0→1. The next frame toggles it 1→0; with the macro undefined it stays 0.
- plot_wr_en during CLEAR → not forwarded to fb_wr_en, overrun_err=1, and it stays 1 until resetn=0.
- run=0 at SWAP → HOLD with plot_resetn=0 and no fb_wr_en for 100 cycles. Raising run → CLEAR starting at address 0.
- Assert resetn=0 mid-PLOT after 3 columns → all outputs at reset values, then a full clear from address 0 and fb_back_sel=0.
